// File: rtl/wb_openram_if.sv
// Wishbone classic slave-side bundle for the banked OpenRAM controller.
// The wbs_err_o line exists only when WB_OPENRAM_ERR_EN is defined.
interface wb_openram_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
`ifdef WB_OPENRAM_ERR_EN
    logic        wbs_err_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o, wbs_err_o
    );
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o, wbs_err_o
    );
`else
    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
`endif
endinterface

// File: rtl/wb_openram_banked_ctrl.sv
// Wishbone classic slave mapping NUM_BANKS OpenRAM RW macros onto one contiguous word region.
// Optional feature: define WB_OPENRAM_ERR_EN to add a wbs_err_o pulse for out-of-region requests.
module wb_openram_banked_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          ADDR_WIDTH   = 8,
    parameter int          NUM_BANKS    = 4,
    parameter int          READ_LATENCY = 1
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    wb_openram_if.slave               wbs,
    output logic                      clk0,
    output logic [NUM_BANKS-1:0]      csb0,
    output logic                      web0,
    output logic [3:0]                wmask0,
    output logic [ADDR_WIDTH-1:0]     addr0,
    input  logic [32*NUM_BANKS-1:0]   din0,
    output logic [31:0]               dout0
);
    localparam int          BANK_BITS    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [32:0] REGION_BYTES = 33'(NUM_BANKS) << (ADDR_WIDTH + 2);
    localparam logic [32:0] REGION_LO    = {1'b0, BASE_ADDR};
    localparam logic [32:0] REGION_HI    = REGION_LO + REGION_BYTES;
    localparam logic [1:0]  LAT_LAST     = 2'(READ_LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_ACK} state_t;

    state_t                  state_reg;
    logic [1:0]              lat_cnt_reg;
    logic                    we_reg;
    logic [BANK_BITS-1:0]    bank_reg;
    logic [NUM_BANKS-1:0]    csb_reg;
    logic                    web_reg;
    logic [3:0]              wmask_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [31:0]             dout_reg;
    logic                    ack_reg;
    logic [31:0]             dat_reg;
`ifdef WB_OPENRAM_ERR_EN
    logic                    err_reg;
`endif

    logic [ADDR_WIDTH-1:0]   req_word;
    logic [BANK_BITS-1:0]    req_bank;
    logic                    req_valid;
    logic                    req_hit;
    logic [NUM_BANKS-1:0]    req_csb;
    logic [31:0]             din_bank [NUM_BANKS];

    assign req_word  = wbs.wbs_adr_i[ADDR_WIDTH+1:2];
    assign req_bank  = wbs.wbs_adr_i[ADDR_WIDTH+BANK_BITS+1:ADDR_WIDTH+2];
    assign req_valid = wbs.wbs_stb_i & wbs.wbs_cyc_i;
    assign req_hit   = ({1'b0, wbs.wbs_adr_i} >= REGION_LO) &&
                       ({1'b0, wbs.wbs_adr_i} <  REGION_HI) &&
                       (32'(req_bank) < 32'(NUM_BANKS));

    // Per-bank select decode and read-data split of the packed macro bus.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BANKS; gi = gi + 1) begin : g_bank
            assign req_csb[gi]  = (req_bank != BANK_BITS'(gi));
            assign din_bank[gi] = din0[32*gi +: 32];
        end
    endgenerate

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg   <= ST_IDLE;
            lat_cnt_reg <= 2'd0;
            we_reg      <= 1'b0;
            bank_reg    <= '0;
            csb_reg     <= '1;
            web_reg     <= 1'b1;
            wmask_reg   <= 4'd0;
            addr_reg    <= '0;
            dout_reg    <= 32'd0;
            ack_reg     <= 1'b0;
            dat_reg     <= 32'd0;
`ifdef WB_OPENRAM_ERR_EN
            err_reg     <= 1'b0;
`endif
        end else begin
`ifdef WB_OPENRAM_ERR_EN
            err_reg <= 1'b0;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid && req_hit) begin
                        state_reg <= ST_ACCESS;
                        we_reg    <= wbs.wbs_we_i;
                        bank_reg  <= req_bank;
                        csb_reg   <= req_csb;
                        web_reg   <= ~wbs.wbs_we_i;
                        addr_reg  <= req_word;
                        wmask_reg <= wbs.wbs_sel_i;
                        dout_reg  <= wbs.wbs_dat_i;
                    end
`ifdef WB_OPENRAM_ERR_EN
                    // Toggling against the previous pulse makes a held miss error every other cycle.
                    else if (req_valid) begin
                        err_reg <= ~err_reg;
                    end
`endif
                end
                ST_ACCESS: begin
                    csb_reg     <= '1;
                    web_reg     <= 1'b1;
                    lat_cnt_reg <= 2'd0;
                    if (we_reg) begin
                        state_reg <= ST_ACK;
                        ack_reg   <= 1'b1;
                    end else begin
                        state_reg <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!wbs.wbs_cyc_i) begin
                        state_reg   <= ST_IDLE;
                        lat_cnt_reg <= 2'd0;
                    end else if (lat_cnt_reg == LAT_LAST) begin
                        state_reg   <= ST_ACK;
                        ack_reg     <= 1'b1;
                        dat_reg     <= din_bank[bank_reg];
                        lat_cnt_reg <= 2'd0;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + 2'd1;
                    end
                end
                ST_ACK: begin
                    ack_reg   <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign clk0          = wb_clk_i;
    assign csb0          = csb_reg;
    assign web0          = web_reg;
    assign wmask0        = wmask_reg;
    assign addr0         = addr_reg;
    assign dout0         = dout_reg;
    assign wbs.wbs_ack_o = ack_reg;
    assign wbs.wbs_dat_o = dat_reg;
`ifdef WB_OPENRAM_ERR_EN
    assign wbs.wbs_err_o = err_reg;
`endif
endmodule
